// File: rtl/hazard_pkg.sv
// Shared constants and types for the pending-write hazard scoreboard.
package hazard_pkg;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  // Widest register address the EX tracker can hold (256 registers).
  localparam int unsigned MAX_ADDR_W   = 8;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  vld;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  long_op;
  } ex_track_t;

endpackage

// File: rtl/hazard_src_check.sv
// Per-source RAW comparator: flags a read of a register with an outstanding long write.
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                used_i,
  input  logic [NUM_REGS-1:0] pending_eff_i,
  output logic                hit_o
);

  logic addr_nz;

  assign addr_nz = (addr_i != ADDR_W'(REG_ZERO));
  assign hit_o   = used_i & addr_nz & pending_eff_i[addr_i];

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX pending-write scoreboard: stalls on RAW/WAW against outstanding long-latency writes.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,   // must equal $clog2(NUM_REGS), <= MAX_ADDR_W
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]        src_used_i,
  input  logic [ADDR_W-1:0]         id_rd_i,
  input  logic                      id_wr_en_i,
  input  logic                      id_long_i,
  input  logic                      ex_ready_i,
  input  logic                      flush_ex_i,
  input  logic                      wb_valid_i,
  input  logic [ADDR_W-1:0]         wb_rd_i,
  output logic                      stall_o,
  output logic                      issue_o,
  output logic [NUM_REGS-1:0]       pending_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] wb_mask, pending_eff;
  ex_track_t           ex_q, ex_d;
  logic [NUM_SRC-1:0]  src_hit;
  logic                id_rd_nz, wb_rd_nz;
  logic                raw, waw, stall, issue;
  logic                set_long;

  assign id_rd_nz = (id_rd_i != ADDR_W'(REG_ZERO));
  assign wb_rd_nz = (wb_rd_i != ADDR_W'(REG_ZERO));

  // Same-cycle writeback bypass: the regfile is write-through.
  always_comb begin
    wb_mask = '0;
    if (wb_valid_i && wb_rd_nz) begin
      wb_mask[wb_rd_i] = 1'b1;
    end
  end

  assign pending_eff = pending_q & ~wb_mask;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    hazard_src_check #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
    ) u_src_check (
      .addr_i        (src_addr_i[k*ADDR_W +: ADDR_W]),
      .used_i        (src_used_i[k]),
      .pending_eff_i (pending_eff),
      .hit_o         (src_hit[k])
    );
  end

  assign raw      = |src_hit;
  assign waw      = id_wr_en_i & id_rd_nz & pending_eff[id_rd_i];
  assign stall    = id_valid_i & (raw | waw) & ~flush_ex_i;
  assign issue    = id_valid_i & ~stall & ex_ready_i & ~flush_ex_i;
  assign set_long = issue & id_wr_en_i & id_long_i & id_rd_nz;

  // Statement order encodes per-bit priority: issue set > flush clear > wb clear.
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (flush_ex_i && ex_q.vld && ex_q.long_op) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (ex_q.rd == MAX_ADDR_W'(r)) begin
          pending_d[r] = 1'b0;
        end
      end
    end
    if (set_long) begin
      pending_d[id_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    ex_d = ex_q;
    if (issue) begin
      ex_d.vld     = 1'b1;
      ex_d.rd      = MAX_ADDR_W'(id_rd_i);
      ex_d.long_op = id_long_i & id_wr_en_i;
    end else if (ex_ready_i || flush_ex_i) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ex_q      <= '0;
    end else begin
      pending_q <= pending_d;
      ex_q      <= ex_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign stall_o   = stall;
  assign issue_o   = issue;
  assign pending_o = pending_q;
  assign busy_o    = |pending_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs a set model.
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          id_valid;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0] src_used;
  logic [AW-1:0] id_rd;
  logic          id_wr_en, id_long, ex_ready, flush_ex, wb_valid;
  logic [AW-1:0] wb_rd;
  logic          stall_o, issue_o, busy_o;
  logic [NR-1:0] pending_o;
  logic [CW-1:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .NUM_SRC  (NS),
    .CNT_W    (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .id_valid_i  (id_valid),
    .src_addr_i  (src_addr),
    .src_used_i  (src_used),
    .id_rd_i     (id_rd),
    .id_wr_en_i  (id_wr_en),
    .id_long_i   (id_long),
    .ex_ready_i  (ex_ready),
    .flush_ex_i  (flush_ex),
    .wb_valid_i  (wb_valid),
    .wb_rd_i     (wb_rd),
    .stall_o     (stall_o),
    .issue_o     (issue_o),
    .pending_o   (pending_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  // Reference model: set of registers with an outstanding long write, plus the op in EX.
  int m_pend[$];
  bit m_ex_vld;
  int m_ex_rd;
  bit m_ex_long;
  int m_stalls;
  bit e_stall, e_issue;

  function automatic bit has(int r);
    foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void drop(int r);
    int idx[$];
    idx = m_pend.find_first_index(x) with (x == r);
    if (idx.size() > 0) m_pend.delete(idx[0]);
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    foreach (m_pend[i]) v[m_pend[i]] = 1'b1;
    return v;
  endfunction

  function automatic void model_comb();
    int  wb = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -1;
    bit  hz = 1'b0;
    int  a;
    for (int k = 0; k < NS; k++) begin
      a = int'(src_addr[k*AW +: AW]);
      if (src_used[k] && a != 0 && has(a) && a != wb) hz = 1'b1;
    end
    if (id_wr_en && id_rd != 0 && has(int'(id_rd)) && int'(id_rd) != wb) hz = 1'b1;
    e_stall = id_valid && hz && !flush_ex;
    e_issue = id_valid && !e_stall && ex_ready && !flush_ex;
  endfunction

  function automatic void model_seq();
    if (wb_valid && wb_rd != 0) drop(int'(wb_rd));
    if (flush_ex && m_ex_vld && m_ex_long) drop(m_ex_rd);
    if (e_issue && id_wr_en && id_long && id_rd != 0 && !has(int'(id_rd)))
      m_pend.push_back(int'(id_rd));
    if (e_stall && m_stalls < (2**CW) - 1) m_stalls++;
    if (e_issue) begin
      m_ex_vld  = 1'b1;
      m_ex_rd   = int'(id_rd);
      m_ex_long = id_long && id_wr_en;
    end else if (ex_ready || flush_ex) begin
      m_ex_vld  = 1'b0;
      m_ex_rd   = 0;
      m_ex_long = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef HAZARD_PERF_EN
    return 32'(m_stalls);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; src_addr = '0; src_used = '0; id_rd = '0; id_wr_en = 0; id_long = 0;
    ex_ready = 1; flush_ex = 0; wb_valid = 0; wb_rd = '0;
  endtask

  // Check combinational outputs, clock once, then check registered state.
  task automatic tick();
    #1;
    model_comb();
    check("stall", 32'(stall_o), 32'(e_stall));
    check("issue", 32'(issue_o), 32'(e_issue));
    @(posedge clk);
    model_seq();
    #1;
    check("pending", 32'(pending_o), pend_vec());
    check("busy", 32'(busy_o), 32'(m_pend.size() != 0));
    check("stall_cnt", 32'(stall_cnt_o), exp_cnt());
  endtask

  task automatic issue_long(input int rd);
    idle();
    id_valid = 1; id_rd = AW'(rd); id_wr_en = 1; id_long = 1;
    tick();
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_ex_vld = 0; m_ex_rd = 0; m_ex_long = 0; m_stalls = 0;
  endtask

  initial begin
    model_reset();
    idle();
    #12;
    check("reset_pending", 32'(pending_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_stall", 32'(stall_o), 32'h0);
    check("reset_issue", 32'(issue_o), 32'h0);
    check("reset_cnt", 32'(stall_cnt_o), 32'h0);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;

    // Load-use delay
    issue_long(5);
    check("lu_pending", 32'(pending_o), 32'h20);
    idle();
    id_valid = 1; src_addr = {5'd0, 5'd5}; src_used = 2'b01; id_rd = 5'd6; id_wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("lu_stall", 32'(stall_o), 32'h1);
      tick();
    end
    wb_valid = 1; wb_rd = 5'd5;
    #1;
    check("lu_wb_stall", 32'(stall_o), 32'h0);
    check("lu_wb_issue", 32'(issue_o), 32'h1);
    tick();
    check("lu_after", 32'(pending_o), 32'h0);

    // Zero register
    issue_long(0);
    check("zero_pending", 32'(pending_o), 32'h0);
    idle();
    id_valid = 1; src_addr = '0; src_used = 2'b11;
    #1 check("zero_stall", 32'(stall_o), 32'h0);
    tick();

    // WAW
    issue_long(7);
    check("waw_pending", 32'(pending_o), 32'h80);
    idle();
    id_valid = 1; id_rd = 5'd7; id_wr_en = 1;
    #1 check("waw_stall", 32'(stall_o), 32'h1);
    tick();
    wb_valid = 1; wb_rd = 5'd7;
    #1 check("waw_wb_stall", 32'(stall_o), 32'h0);
    tick();

    // Flush release
    issue_long(9);
    check("fl_pending", 32'(pending_o), 32'h200);
    idle();
    id_valid = 1; src_addr = {5'd0, 5'd9}; src_used = 2'b01; flush_ex = 1;
    #1;
    check("fl_stall", 32'(stall_o), 32'h0);
    check("fl_issue", 32'(issue_o), 32'h0);
    tick();
    check("fl_after", 32'(pending_o), 32'h0);

    // Set/clear collision
    issue_long(3);
    idle();
    id_valid = 1; id_rd = 5'd3; id_wr_en = 1; id_long = 1; wb_valid = 1; wb_rd = 5'd3;
    #1 check("col_issue", 32'(issue_o), 32'h1);
    tick();
    check("col_bit3", 32'(pending_o[3]), 32'h1);
    idle();
    wb_valid = 1; wb_rd = 5'd3;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      id_valid = ($urandom_range(0, 9) < 8);
      src_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      src_used = 2'($urandom_range(0, 3));
      id_rd    = 5'($urandom_range(0, 7));
      id_wr_en = $urandom_range(0, 3) != 0;
      id_long  = $urandom_range(0, 1) == 1;
      ex_ready = $urandom_range(0, 9) < 7;
      flush_ex = $urandom_range(0, 9) == 0;
      wb_valid = $urandom_range(0, 9) < 3;
      if (m_pend.size() != 0 && $urandom_range(0, 3) != 0)
        wb_rd = AW'(m_pend[$urandom_range(0, m_pend.size() - 1)]);
      else
        wb_rd = 5'($urandom_range(0, 7));
      tick();
    end

    // Drain, then async reset mid-operation
    idle();
    while (m_pend.size() != 0) begin
      wb_valid = 1; wb_rd = AW'(m_pend[0]);
      tick();
    end
    issue_long(5);
    issue_long(10);
    idle();
    check("ar_pending_before", 32'(pending_o), 32'h420);
    #3;
    rst_ni = 0;
    #1;
    model_reset();
    check("ar_pending", 32'(pending_o), 32'h0);
    check("ar_busy", 32'(busy_o), 32'h0);
    check("ar_cnt", 32'(stall_cnt_o), 32'h0);
    @(negedge clk);
    rst_ni = 1;
    @(posedge clk);
    #1;

    // Held stall saturates the counter
    issue_long(5);
    idle();
    id_valid = 1; src_addr = {5'd5, 5'd0}; src_used = 2'b10;
    for (int i = 0; i < 20; i++) tick();
`ifdef HAZARD_PERF_EN
    check("cnt_sat", 32'(stall_cnt_o), 32'd15);
`else
    check("cnt_tied", 32'(stall_cnt_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
